// File: rtl/npc_pkg.sv
// Shared definitions for the pipeline back end: writeback FSM states,
// load funct3 encodings and default datapath widths.
package npc_pkg;

    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wbu_state_t;

endpackage

// File: rtl/load_ext.sv
// Combinational load-data extractor: picks the byte/halfword addressed by
// off out of the aligned memory word and sign- or zero-extends it.
module load_ext
    import npc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [2:0]            funct3,
    input  logic [1:0]            off,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            2'd3:    byte_sel = rdata[31:24];
            default: byte_sel = rdata[7:0];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];

        // Unsupported codes still retire, so they produce a harmless zero.
        data = '0;
        case (funct3)
            LB:      data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            LH:      data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            LW:      data = rdata;
            LBU:     data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            LHU:     data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data = '0;
        endcase
    end

endmodule

// File: rtl/wbu.sv
// Writeback unit: retires instructions from execute, waits for load data
// when needed, and drives the register-file write port and commit trace.
module wbu
    import npc_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] in_rd,
    input  logic [DATA_WIDTH-1:0] in_res,
    input  logic                  in_is_load,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_off,
    input  logic [31:0]           in_pc,
    input  logic                  lsu_rvalid,
    input  logic [DATA_WIDTH-1:0] lsu_rdata,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [31:0]           commit_pc,
    output logic [31:0]           commit_cnt
);

    wbu_state_t            state;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic [31:0]           pc_q;
    logic [DATA_WIDTH-1:0] ext_data;

    load_ext #(.DATA_WIDTH(DATA_WIDTH)) u_load_ext (
        .funct3 (funct3_q),
        .off    (off_q),
        .rdata  (lsu_rdata),
        .data   (ext_data)
    );

    assign in_ready = (state != WAIT_MEM);

    // Write-port and commit outputs are loaded on the edge that enters
    // WRITE, so they are valid for exactly the single WRITE cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_q         <= '0;
            funct3_q     <= '0;
            off_q        <= '0;
            pc_q         <= '0;
            rf_wen       <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_cnt   <= '0;
        end else begin
            rf_wen       <= 1'b0;
            commit_valid <= 1'b0;
            case (state)
                IDLE, WRITE: begin
                    if (in_valid) begin
                        rd_q <= in_rd;
                        pc_q <= in_pc;
                        if (in_is_load) begin
                            funct3_q <= in_funct3;
                            off_q    <= in_off;
                            state    <= WAIT_MEM;
                        end else begin
                            rf_wen       <= (in_rd != '0);
                            rf_waddr     <= in_rd;
                            rf_wdata     <= in_res;
                            commit_valid <= 1'b1;
                            commit_pc    <= in_pc;
                            commit_cnt   <= commit_cnt + 32'd1;
                            state        <= WRITE;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (lsu_rvalid) begin
                        rf_wen       <= (rd_q != '0);
                        rf_waddr     <= rd_q;
                        rf_wdata     <= ext_data;
                        commit_valid <= 1'b1;
                        commit_pc    <= pc_q;
                        commit_cnt   <= commit_cnt + 32'd1;
                        state        <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/wbu.md
WBU -- requirements
Module: wbu

Interface
REQ-001 Parameter ADDR_WIDTH, default 5, SHALL set the width of the register-file address.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the width of the result and load data.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: synchronous, active-low.
REQ-005 in_valid  in  1  SHALL indicate that the execute stage presents a retiring instruction.
REQ-006 in_ready  out  1  SHALL indicate that wbu accepts the instruction this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-007 in_rd  in  ADDR_WIDTH  SHALL carry the destination register.
REQ-008 in_res  in  DATA_WIDTH  SHALL carry the ALU result for non-load instructions.
REQ-009 in_is_load  in  1  SHALL mark the instruction as a load.
REQ-010 in_funct3  in  3  SHALL carry the load size/sign code.
REQ-011 in_off  in  2  SHALL carry the byte offset, address[1:0].
REQ-012 in_pc  in  32  SHALL carry the instruction PC.
REQ-013 lsu_rvalid  in  1  SHALL carry the one-cycle load-data-return strobe.
REQ-014 lsu_rdata  in  DATA_WIDTH  SHALL carry the raw aligned memory word.
REQ-015 rf_wen, rf_waddr (ADDR_WIDTH), rf_wdata (DATA_WIDTH)  out  SHALL form the register-file write port.
REQ-016 commit_valid  out  1  SHALL pulse once per retired instruction; commit_pc  out  32  SHALL give its PC.
REQ-017 commit_cnt  out  32  SHALL count retired instructions.

Function
REQ-018 wbu SHALL implement the FSM states IDLE, WAIT_MEM and WRITE.
REQ-019 in_ready SHALL be 1 in IDLE and WRITE, and 0 in WAIT_MEM.
REQ-020 Non-load accepted: latch rd/in_res/pc and enter WRITE next cycle; write latency is exactly 1 cycle after acceptance.
REQ-021 Load accepted: latch rd/funct3/off/pc and enter WAIT_MEM.
REQ-022 WAIT_MEM with lsu_rvalid=1: latch the extended data and enter WRITE; with lsu_rvalid=0: remain, with no timeout.
REQ-023 WRITE SHALL last exactly one cycle.
  - Signals: commit_valid=1 and commit_pc=latched pc; rf_wen=1 only if latched rd != 0; rf_waddr/rf_wdata from the latched values.
  - No acceptance that cycle: next state is IDLE.
  - Acceptance that cycle: next state is WRITE (non-load) or WAIT_MEM (load), so back-to-back non-loads retire one per cycle.
REQ-024 rd == 0 SHALL still commit (commit_valid=1, counter increments) with rf_wen=0.
REQ-025 lsu_rvalid in IDLE or WRITE, including the cycle a load is accepted, SHALL be ignored.
REQ-026 Load extension by funct3:
  - 000 lb: byte at off, sign-extended.
  - 001 lh: halfword at off[1], sign-extended; off[0] ignored.
  - 010 lw: word as-is; off ignored.
  - 100 lbu: byte at off, zero-extended.
  - 101 lhu: halfword at off[1], zero-extended.
  - Any other code: data 0, instruction still commits.
REQ-027 commit_cnt SHALL increment by 1 per commit_valid cycle and wrap 0xFFFFFFFF -> 0.
REQ-028 rf_wen and commit_valid SHALL never be 1 outside WRITE.

Reset
REQ-029 While rst_n=0 at a clock edge:
  - State: IDLE.
  - Outputs: rf_wen=0, commit_valid=0, commit_cnt=0, rf_waddr=0, rf_wdata=0, commit_pc=0.
  - Latches: all cleared to 0.
REQ-030 Reset in WAIT_MEM or WRITE SHALL discard the pending instruction with no write; a later lsu_rvalid for it SHALL be ignored.
REQ-031 in_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-032 Shared package npc_pkg SHALL hold:
  - The wbu state enum.
  - funct3 load constants (LB, LH, LW, LBU, LHU).
  - Default ADDR_WIDTH/DATA_WIDTH.
REQ-033 Load extension SHALL be a combinational sub-module load_ext (inputs funct3, off, rdata; output extended data), instantiated once.

Verification
REQ-034 ALU op: accept rd=5, res=0x1234, pc=0x80000000 -> next cycle rf_wen=1, waddr=5, wdata=0x1234, commit_valid=1, commit_cnt=1.
REQ-035 lb: rdata=0x80FF7F01, off=1, funct3=000, lsu_rvalid 3 cycles later -> in_ready=0 for 3 cycles; write data 0x0000007F (with off=3: 0xFFFFFF80); lhu off=2 -> 0x000080FF.
REQ-036 Back-to-back: 4 consecutive non-loads with in_valid=1 -> 4 consecutive rf_wen cycles in order, commit_cnt=4.
REQ-037 rd=0 ALU op -> rf_wen=0, commit_valid=1, commit_cnt increments; spurious lsu_rvalid in IDLE -> no write.
REQ-038 Reset asserted for 1 cycle in WAIT_MEM, then lsu_rvalid -> no rf_wen, commit_cnt=0, in_ready=1.
